// File: rtl/umi_pkg.sv
// Shared UMI definitions: arbitration mode encodings and command-field bit positions.
package umi_pkg;

  typedef enum logic [1:0] {
    ARB_FIXED  = 2'b00,
    ARB_RR     = 2'b01,
    ARB_WRR    = 2'b10,
    ARB_RR_ALT = 2'b11
  } arb_mode_e;

  localparam int unsigned EOM_BIT = 22;

endpackage

// File: rtl/umi_arbiter_wrr.sv
// Packet arbiter for the UMI mux: fixed priority, round-robin and weighted round-robin.
// The grant is combinational; pointer and credit advance only when a granted packet's EOM transfers.
module umi_arbiter_wrr
  import umi_pkg::*;
#(
  parameter int N  = 4,
  parameter int WW = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [1:0]      mode,
  input  logic [N-1:0]    req,
  input  logic [N*WW-1:0] weight,
  input  logic            done,
  input  logic [IW-1:0]   done_ch,
  output logic            gnt_vld,
  output logic [IW-1:0]   gnt_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cur_q, cur_d;
  logic [WW:0]   credit_q, credit_d;
  logic [WW:0]   credit_load;
  logic [IW-1:0] fix_idx, rr_idx;
  logic          keep;
  arb_mode_e     mode_e;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] a, input int unsigned k);
    int unsigned s;
    s = 32'(a) + k;
    if (s >= 32'(N)) s = s - 32'(N);
    return IW'(s);
  endfunction

  // Scanning downward leaves the lowest-ranked (highest-priority) requester in each index.
  always_comb begin
    mode_e  = arb_mode_e'(mode);
    fix_idx = '0;
    rr_idx  = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fix_idx = IW'(i);
      if (req[wrap_inc(ptr_q, i)]) rr_idx = wrap_inc(ptr_q, i);
    end
    keep    = (mode_e == ARB_WRR) && (credit_q != '0) && req[cur_q];
    gnt_vld = |req;
    if (mode_e == ARB_FIXED) gnt_idx = fix_idx;
    else if (keep)           gnt_idx = cur_q;
    else                     gnt_idx = rr_idx;
  end

  always_comb begin
    ptr_d       = ptr_q;
    cur_d       = cur_q;
    credit_d    = credit_q;
    credit_load = {1'b0, weight[int'(done_ch)*WW +: WW]} + 1'b1;
    if (done) begin
      ptr_d = wrap_inc(done_ch, 1);
      cur_d = done_ch;
      if (mode_e != ARB_WRR)                        credit_d = '0;
      else if (done_ch == cur_q && credit_q != '0)  credit_d = credit_q - 1'b1;
      else                                          credit_d = credit_load - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      ptr_q    <= '0;
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

endmodule

// File: rtl/umi_mux_pkt.sv
// N-to-1 UMI packet mux: holds the packet lock and a one-entry registered output stage.
// Arbitration itself lives in umi_arbiter_wrr and is consulted only while unlocked.
module umi_mux_pkt
  import umi_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 256,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int WW = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [1:0]      arbmode,
  input  logic [N-1:0]    arbmask,
  input  logic [N*WW-1:0] arbweight,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          lock_q, lock_d;
  logic [IW-1:0] lock_ch_q, lock_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_cmd_q, out_cmd_d;
  logic [AW-1:0] out_dst_q, out_dst_d;
  logic [AW-1:0] out_src_q, out_src_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic [N-1:0]  arb_req;
  logic          arb_vld;
  logic [IW-1:0] arb_idx;
  logic [IW-1:0] sel;
  logic          sel_vld, stage_free, ready_any, fire, eom;
  logic [CW-1:0] sel_cmd;

  assign arb_req = umi_in_valid & ~arbmask;

  umi_arbiter_wrr #(.N(N), .WW(WW)) u_arb (
    .clk     (clk),
    .nreset  (nreset),
    .mode    (arbmode),
    .req     (arb_req),
    .weight  (arbweight),
    .done    (fire && eom),
    .done_ch (sel),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  // A locked channel keeps its grant even if masked mid-packet; reset forces ready low.
  always_comb begin
    sel          = lock_q ? lock_ch_q : arb_idx;
    sel_vld      = nreset && (lock_q || arb_vld);
    stage_free   = !out_valid_q || umi_out_ready;
    ready_any    = sel_vld && stage_free;
    umi_in_ready = '0;
    if (ready_any) umi_in_ready[sel] = 1'b1;
    sel_cmd      = umi_in_cmd[int'(sel)*CW +: CW];
    fire         = ready_any && umi_in_valid[sel];
    eom          = sel_cmd[EOM_BIT];

    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_dst_d   = out_dst_q;
    out_src_d   = out_src_q;
    out_data_d  = out_data_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_cmd_d   = sel_cmd;
      out_dst_d   = umi_in_dstaddr[int'(sel)*AW +: AW];
      out_src_d   = umi_in_srcaddr[int'(sel)*AW +: AW];
      out_data_d  = umi_in_data[int'(sel)*DW +: DW];
      lock_d      = !eom;
      lock_ch_d   = sel;
    end else if (umi_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      out_data_q  <= '0;
    end else begin
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_dst_q   <= out_dst_d;
      out_src_q   <= out_src_d;
      out_data_q  <= out_data_d;
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dst_q;
  assign umi_out_srcaddr = out_src_q;
  assign umi_out_data    = out_data_q;

endmodule

// File: tb/tb_umi_mux_pkt.sv
// Scoreboard bench for umi_mux_pkt: packet-level reference arbiter predicts the merged flit stream.
// Channel id rides in data[3:0] so the output order can be checked against fixed patterns.
module tb_umi_mux_pkt;
  import umi_pkg::*;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int WW = 4;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } flit_t;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic [1:0]      arbmode = 2'b00;
  logic [N-1:0]    arbmask = '0;
  logic [N*WW-1:0] arbweight = '0;
  logic [N-1:0]    umi_in_valid;
  logic [N*CW-1:0] umi_in_cmd;
  logic [N*AW-1:0] umi_in_dstaddr;
  logic [N*AW-1:0] umi_in_srcaddr;
  logic [N*DW-1:0] umi_in_data;
  logic [N-1:0]    umi_in_ready;
  logic            umi_out_valid;
  logic [CW-1:0]   umi_out_cmd;
  logic [AW-1:0]   umi_out_dstaddr;
  logic [AW-1:0]   umi_out_srcaddr;
  logic [DW-1:0]   umi_out_data;
  logic            umi_out_ready = 1'b1;

  always #5 clk = ~clk;

  umi_mux_pkt #(.N(N), .DW(DW), .CW(CW), .AW(AW), .WW(WW)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .arbmode         (arbmode),
    .arbmask         (arbmask),
    .arbweight       (arbweight),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready)
  );

  flit_t drv_q[N][$];
  flit_t mdl_q[N][$];
  flit_t exp_q[$];
  int    rec_q[$];
  int    ts_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    seq = 0;
  bit    sb_en = 1'b1;
  int    m_last, m_cur, m_served;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Input driver: handshakes are sampled at negedge, queues advance just after posedge.
  initial begin : driver
    logic [N-1:0] snap;
    umi_in_valid = '0; umi_in_cmd = '0; umi_in_dstaddr = '0;
    umi_in_srcaddr = '0; umi_in_data = '0;
    forever begin
      @(negedge clk);
      snap = umi_in_valid & umi_in_ready;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (snap[c] && drv_q[c].size() > 0) void'(drv_q[c].pop_front());
        if (drv_q[c].size() > 0) begin
          umi_in_valid[c]               = 1'b1;
          umi_in_cmd[c*CW +: CW]        = drv_q[c][0].cmd;
          umi_in_dstaddr[c*AW +: AW]    = drv_q[c][0].dst;
          umi_in_srcaddr[c*AW +: AW]    = drv_q[c][0].src;
          umi_in_data[c*DW +: DW]       = drv_q[c][0].data;
        end else begin
          umi_in_valid[c] = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    flit_t got, want;
    forever begin
      @(negedge clk);
      if (sb_en && nreset && umi_out_valid && umi_out_ready) begin
        got = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL out_flit: got ch=%0d data=%h, required no flit", got.data[3:0], got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            bad++;
            $display("FAIL out_flit: got ch=%0d data=%h cmd=%h, required ch=%0d data=%h cmd=%h",
                     got.data[3:0], got.data, got.cmd, want.data[3:0], want.data, want.cmd);
          end
        end
        rec_q.push_back(int'(got.data[3:0]));
        ts_q.push_back(cyc);
      end
    end
  end

  task automatic add_pkt(input int c, input int len);
    flit_t f;
    for (int i = 0; i < len; i++) begin
      f.cmd          = $urandom;
      f.cmd[EOM_BIT] = (i == len - 1);
      f.dst          = {$urandom, $urandom};
      f.src          = {$urandom, $urandom};
      f.data         = {$urandom, $urandom};
      f.data[3:0]    = c[3:0];
      f.data[15:8]   = seq[7:0];
      f.data[19:16]  = i[3:0];
      drv_q[c].push_back(f);
      mdl_q[c].push_back(f);
    end
    seq++;
  endtask

  function automatic bit elig(input int c, input logic [N-1:0] mask);
    return (mdl_q[c].size() > 0) && !mask[c];
  endfunction

  // Reference arbiter at packet granularity: pending packets stand in for valid.
  task automatic mdl_run(input logic [1:0] mode, input logic [N-1:0] mask,
                         input logic [N*WW-1:0] wt, input int max_pkts);
    int g, n, w;
    flit_t f;
    n = 0;
    while (n < max_pkts) begin
      g = -1;
      if (mode == 2'b00) begin
        for (int c = N - 1; c >= 0; c--) if (elig(c, mask)) g = c;
      end else begin
        if (mode == 2'b10 && m_cur >= 0 && elig(m_cur, mask)) begin
          w = int'(wt[m_cur*WW +: WW]);
          if (m_served < w + 1) g = m_cur;
        end
        if (g < 0)
          for (int k = N; k >= 1; k--) if (elig((m_last + k) % N, mask)) g = (m_last + k) % N;
      end
      if (g < 0) break;
      if (mode == 2'b10) begin
        w = int'(wt[g*WW +: WW]);
        if (g == m_cur && m_served < w + 1) m_served++;
        else begin m_cur = g; m_served = 1; end
      end else begin
        m_cur = -1; m_served = 0;
      end
      m_last = g;
      do begin
        f = mdl_q[g].pop_front();
        exp_q.push_back(f);
      end while (!f.cmd[EOM_BIT]);
      n++;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    nreset = 1'b0;
    umi_out_ready = 1'b1;
    for (int c = 0; c < N; c++) begin drv_q[c].delete(); mdl_q[c].delete(); end
    exp_q.delete(); rec_q.delete(); ts_q.delete();
    m_last = N - 1; m_cur = -1; m_served = 0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Lets the driver present the freshly loaded queues, then releases reset.
  task automatic start();
    @(posedge clk); #2;
    nreset = 1'b1;
  endtask

  task automatic wait_drain(input bit rnd);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || umi_out_valid) && n < 3000) begin
      umi_out_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      @(posedge clk); #2;
      n++;
    end
    umi_out_ready = 1'b1;
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic stall_check();
    flit_t snap, now;
    int n;
    umi_out_ready = 1'b0;
    n = 0;
    while (!umi_out_valid && n < 20) begin @(posedge clk); #2; n++; end
    check("stall_staged", 64'(umi_out_valid), 64'd1);
    snap = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
    repeat (5) begin
      @(negedge clk);
      now = {umi_out_cmd, umi_out_dstaddr, umi_out_srcaddr, umi_out_data};
      check("stall_hold_data", now.data, snap.data);
      check("stall_hold_cmd", 64'(now.cmd), 64'(snap.cmd));
      check("stall_in_ready", 64'(umi_in_ready), 64'd0);
    end
    @(posedge clk); #2;
    umi_out_ready = 1'b1;
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int wrr_exp[7];
    int cnt, hs;
    logic [N-1:0] m;
    wrr_exp = '{0, 1, 1, 2, 3, 3, 3};

    // fixed priority, 1-flit packets: reset state, latency, ch0 dominates
    do_reset();
    check("rst_out_valid", 64'(umi_out_valid), 64'd0);
    check("rst_in_ready", 64'(umi_in_ready), 64'd0);
    check("rst_out_cmd", 64'(umi_out_cmd), 64'd0);
    check("rst_out_data", umi_out_data, 64'd0);
    check("rst_out_dst", umi_out_dstaddr, 64'd0);
    arbmode = 2'b00;
    for (int i = 0; i < 8; i++) add_pkt(0, 1);
    for (int c = 1; c < N; c++) for (int i = 0; i < 3; i++) add_pkt(c, 1);
    mdl_run(2'b00, arbmask, arbweight, 1000);
    start();
    @(negedge clk);
    check("fix_first_ready", 64'(umi_in_ready), 64'd1);
    @(posedge clk); #2;
    check("fix_latency_valid", 64'(umi_out_valid), 64'd1);
    check("fix_latency_ch", 64'(umi_out_data[3:0]), 64'd0);
    wait_drain(1'b0);
    for (int i = 0; i < 8 && i < rec_q.size(); i++) check("fix_only_ch0", 64'(rec_q[i]), 64'd0);

    // round-robin, 3-flit packets: no interleave, one flit per cycle
    do_reset();
    arbmode = 2'b01;
    for (int c = 0; c < N; c++) add_pkt(c, 3);
    mdl_run(2'b01, arbmask, arbweight, 1000);
    start();
    wait_drain(1'b0);
    check("rr_count", 64'(rec_q.size()), 64'd12);
    for (int i = 0; i < 12 && i < rec_q.size(); i++) check("rr_order", 64'(rec_q[i]), 64'(i / 3));
    if (ts_q.size() >= 12) check("rr_cycles", 64'(ts_q[11] - ts_q[0]), 64'd11);

    // weighted round-robin with weights {0,1,0,2}
    do_reset();
    arbmode = 2'b10;
    arbweight = {4'd2, 4'd0, 4'd1, 4'd0};
    for (int c = 0; c < N; c++) for (int i = 0; i < 6; i++) add_pkt(c, 1);
    mdl_run(2'b10, arbmask, arbweight, 1000);
    start();
    wait_drain(1'b1);
    for (int i = 0; i < 14 && i < rec_q.size(); i++) check("wrr_order", 64'(rec_q[i]), 64'(wrr_exp[i % 7]));

    // randomized modes, weights, masks, packet lengths and backpressure
    for (int it = 0; it < 4; it++) begin
      do_reset();
      arbmode = 2'($urandom_range(0, 3));
      arbweight = 16'($urandom);
      m = 4'($urandom_range(0, 15));
      m[$urandom_range(0, N - 1)] = 1'b0;
      arbmask = m;
      for (int c = 0; c < N; c++) begin
        cnt = $urandom_range(3, 7);
        for (int i = 0; i < cnt; i++) add_pkt(c, $urandom_range(1, 4));
      end
      mdl_run(arbmode, arbmask, arbweight, 1000);
      start();
      if (it == 0) stall_check();
      wait_drain(1'b1);
    end

    // mask applied while ch1 is mid-packet
    do_reset();
    arbmode = 2'b01;
    arbweight = '0;
    arbmask = 4'b1101;
    add_pkt(1, 4);
    add_pkt(1, 2);
    add_pkt(1, 1);
    for (int c = 0; c < N; c++) if (c != 1) for (int i = 0; i < 3; i++) add_pkt(c, $urandom_range(1, 3));
    mdl_run(2'b01, 4'b1101, arbweight, 1);
    start();
    hs = 0;
    cnt = 0;
    while (hs == 0 && cnt < 20) begin
      @(negedge clk);
      if (umi_in_valid[1] && umi_in_ready[1]) hs = 1;
      cnt++;
    end
    check("mask_ch1_started", 64'(hs), 64'd1);
    @(posedge clk); #2;
    arbmask = 4'b0010;
    mdl_run(2'b01, 4'b0010, arbweight, 1000);
    wait_drain(1'b1);
    cnt = 0;
    foreach (rec_q[i]) if (rec_q[i] == 1) cnt++;
    check("mask_ch1_flits", 64'(cnt), 64'd4);
    arbmask = 4'b0000;
    mdl_run(2'b01, 4'b0000, arbweight, 1000);
    wait_drain(1'b0);
    cnt = 0;
    foreach (rec_q[i]) if (rec_q[i] == 1) cnt++;
    check("unmask_ch1_flits", 64'(cnt), 64'd7);

    // reset while ch2 is on flit 2 of 4
    do_reset();
    sb_en = 1'b0;
    arbmode = 2'b01;
    arbmask = 4'b1011;
    add_pkt(2, 4);
    start();
    hs = 0;
    cnt = 0;
    while (hs < 2 && cnt < 20) begin
      @(negedge clk);
      if (umi_in_valid[2] && umi_in_ready[2]) hs++;
      cnt++;
    end
    check("rst_mid_handshakes", 64'(hs), 64'd2);
    @(posedge clk); #2;
    nreset = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_out_valid", 64'(umi_out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(umi_in_ready), 64'd0);
    do_reset();
    arbmask = 4'b0000;
    for (int c = 0; c < N; c++) add_pkt(c, 2);
    mdl_run(2'b01, arbmask, arbweight, 1000);
    sb_en = 1'b1;
    start();
    wait_drain(1'b0);
    check("rst_mid_first_ch", 64'((rec_q.size() > 0) ? rec_q[0] : -1), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/umi_mux_pkt.md
UMI_MUX_PKT -- requirements
Module: umi_mux_pkt

Interface
REQ-001 SHALL have parameter N, default 4, the number of UMI input channels (2..16).
REQ-002 SHALL have parameter DW, default 256, the UMI data width.
REQ-003 SHALL have parameter CW, default 32, the UMI command width.
REQ-004 SHALL have parameter AW, default 64, the UMI address width.
REQ-005 SHALL have parameter WW, default 4, the per-channel arbitration weight width.
REQ-006 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-007 SHALL have port nreset  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port arbmode  input  2  00 fixed priority (ch0 highest), 01 round-robin, 10 weighted round-robin, 11 same as 01.
REQ-009 SHALL have port arbmask  input  N  bit i = 1 excludes channel i from arbitration.
REQ-010 SHALL have port arbweight  input  N*WW  per-channel weight w; the channel gets w+1 packets per turn in mode 10.
REQ-011 SHALL have ports umi_in_valid/cmd/dstaddr/srcaddr/data/ready  in/in/in/in/in/out  N / N*CW / N*AW / N*AW / N*DW / N  packed UMI input channels.
REQ-012 SHALL have ports umi_out_valid/cmd/dstaddr/srcaddr/data  output  1/CW/AW/AW/DW  merged UMI output.
REQ-013 SHALL have port umi_out_ready  input  1  downstream ready.

Function
REQ-014 SHALL transfer a flit on a port whenever valid and ready are both high on a rising edge; valid SHALL NOT depend combinationally on ready.
REQ-015 SHALL treat a flit with cmd bit 22 (EOM) = 1 as the last flit of a packet.
REQ-016 SHALL lock the grant to the winning channel from its first flit until its EOM flit transfers; no other channel receives ready while locked.
REQ-017 SHALL arbitrate only when unlocked, over channels with valid=1 and arbmask=0; with no eligible channel, no flit is accepted.
REQ-018 SHALL, in mode 01, rotate priority so the channel after the last-granted channel has highest priority.
REQ-019 SHALL, in mode 10, keep a credit counter loaded with w+1 on each new turn, decrement it per EOM transfer, and keep the current channel while credit > 0 and it requests; otherwise advance as in mode 01.
REQ-020 SHALL sample arbmode, arbmask and arbweight only at packet boundaries; changes mid-packet take effect on the next arbitration.
REQ-021 SHALL register the output in a one-entry stage: a flit accepted at edge k is presented on umi_out_* after edge k (1-cycle latency).
REQ-022 SHALL assert umi_in_ready[g] = (stage empty or umi_out_ready) for granted channel g only, sustaining one flit per cycle.
REQ-023 SHALL hold umi_out_* stable while umi_out_valid=1 and umi_out_ready=0.
REQ-024 SHALL keep the lock on a masked channel until its EOM transfers (mask never truncates a packet).
REQ-025 SHALL allow a new packet to be granted in the same cycle the previous EOM leaves the stage.

Reset
REQ-026 SHALL, while nreset=0 at a rising edge, clear umi_out_valid and umi_in_ready to 0, clear lock, set round-robin pointer to channel 0 and credit to 0.
REQ-027 SHALL drive umi_out_cmd/dstaddr/srcaddr/data to 0 after reset.
REQ-028 SHALL, on reset mid-packet, discard the staged flit and partial lock; the next packet arbitrates fresh.

Structure
REQ-029 SHALL place arbmode encodings and the EOM bit index constant in shared package umi_pkg.
REQ-030 SHALL implement arbitration (priority, rotate, credit) in sub-module umi_arbiter_wrr; the mux top holds lock and output stage.

Verification
REQ-031 SHALL verify: N=4, mode 00, all channels send 1-flit packets continuously -> only ch0 transfers; out valid 1 cycle after first accept.
REQ-032 SHALL verify: mode 01, all send 3-flit packets -> output order ch0,ch0,ch0,ch1x3,ch2x3,ch3x3, no interleaving, 12 flits in 12 cycles.
REQ-033 SHALL verify: mode 10, weights {0,1,0,2}, 1-flit packets all requesting -> per round 1,2,1,3 packets from ch0..ch3.
REQ-034 SHALL verify: ch1 mid-packet, arbmask=4'b0010 set -> ch1 completes to EOM, then never granted until unmasked.
REQ-035 SHALL verify: umi_out_ready held 0 for 5 cycles with flit staged -> outputs stable, no inputs ready, no flit lost or duplicated.
REQ-036 SHALL verify: nreset pulsed low during ch2 packet flit 2 of 4 -> umi_out_valid=0 next cycle, next grant from ch0 in mode 01.
